// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default register-file widths and the
// occupancy encoding used by the MEM/WB latch.
package pipeline_pkg;

    // Must match the register-file definitions.
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Occupancy encoding (number of held entries).
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage : pipeline_pkg

// File: rtl/wb_entry_reg.sv
// One MEM/WB entry: CHANNELS x (enable, address, data), loaded on load_i,
// cleared asynchronously by reset.
module wb_entry_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CHANNELS   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           load_i,
    input  logic [CHANNELS-1:0]            enable_d,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] address_d,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_d,
    output logic [CHANNELS-1:0]            enable_q,
    output logic [CHANNELS*ADDR_WIDTH-1:0] address_q,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_q
);

    // Capture the whole entry when loaded; contents otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_q  <= '0;
            address_q <= '0;
            data_q    <= '0;
        end else if (load_i) begin
            enable_q  <= enable_d;
            address_q <= address_d;
            data_q    <= data_d;
        end
    end

endmodule : wb_entry_reg

// File: rtl/latch_mem_wb_skid.sv
// MEM->WB pipeline latch with a two-entry skid buffer. Entry A is the head
// driving writeback; entry B absorbs one extra entry while writeback stalls.
// mem_ready depends only on registered state so no combinational path runs
// from wb_ready back to the memory stage.
module latch_mem_wb_skid
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CHANNELS   = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           mem_valid,
    output logic                           mem_ready,
    input  logic [CHANNELS-1:0]            mem_register_write_enable,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] mem_register_write_address,
    input  logic [CHANNELS*DATA_WIDTH-1:0] mem_register_write_data,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [CHANNELS-1:0]            wb_register_write_enable,
    output logic [CHANNELS*ADDR_WIDTH-1:0] wb_register_write_address,
    output logic [CHANNELS*DATA_WIDTH-1:0] wb_register_write_data,
    output logic [1:0]                     occupancy
);

    // State encoded directly as {valid_a, valid_b}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic valid_a_q, valid_a_d;
    logic valid_b_q, valid_b_d;
    logic load_a, load_b, a_from_b;
    logic accept, pop;

    logic [CHANNELS-1:0]            enable_a_q, enable_b_q, enable_a_d;
    logic [CHANNELS*ADDR_WIDTH-1:0] address_a_q, address_b_q, address_a_d;
    logic [CHANNELS*DATA_WIDTH-1:0] data_a_q, data_b_q, data_a_d;

    assign mem_ready = !valid_b_q;
    assign wb_valid  = valid_a_q;
    assign accept    = mem_valid & mem_ready;
    assign pop       = valid_a_q & wb_ready;

    // Next-state and load decisions; flush overrides any handshake.
    always_comb begin
        valid_a_d = valid_a_q;
        valid_b_d = valid_b_q;
        load_a    = 1'b0;
        load_b    = 1'b0;
        a_from_b  = 1'b0;
        if (flush) begin
            valid_a_d = 1'b0;
            valid_b_d = 1'b0;
        end else begin
            case ({valid_a_q, valid_b_q})
                ST_EMPTY: begin
                    if (accept) begin
                        load_a    = 1'b1;
                        valid_a_d = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_a = 1'b1;
                    end else if (accept) begin
                        load_b    = 1'b1;
                        valid_b_d = 1'b1;
                    end else if (pop) begin
                        valid_a_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        load_a    = 1'b1;
                        a_from_b  = 1'b1;
                        valid_b_d = 1'b0;
                    end
                end
                default: begin
                    // B without A is unreachable; recover to empty.
                    valid_a_d = 1'b0;
                    valid_b_d = 1'b0;
                end
            endcase
        end
    end

    // Head entry takes either the incoming entry or the skid contents.
    always_comb begin
        enable_a_d  = a_from_b ? enable_b_q  : mem_register_write_enable;
        address_a_d = a_from_b ? address_b_q : mem_register_write_address;
        data_a_d    = a_from_b ? data_b_q    : mem_register_write_data;
    end

    // Valid bits: the only architecturally significant state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    wb_entry_reg #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CHANNELS(CHANNELS)
    ) u_entry_a (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load_a),
        .enable_d (enable_a_d),
        .address_d(address_a_d),
        .data_d   (data_a_d),
        .enable_q (enable_a_q),
        .address_q(address_a_q),
        .data_q   (data_a_q)
    );

    wb_entry_reg #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CHANNELS(CHANNELS)
    ) u_entry_b (
        .clock    (clock),
        .reset    (reset),
        .load_i   (load_b),
        .enable_d (mem_register_write_enable),
        .address_d(mem_register_write_address),
        .data_d   (mem_register_write_data),
        .enable_q (enable_b_q),
        .address_q(address_b_q),
        .data_q   (data_b_q)
    );

    assign wb_register_write_enable  = enable_a_q & {CHANNELS{valid_a_q}};
    assign wb_register_write_address = address_a_q;
    assign wb_register_write_data    = data_a_q;
    assign occupancy = {1'b0, valid_a_q} + {1'b0, valid_b_q};

endmodule : latch_mem_wb_skid

// File: tb/tb_latch_mem_wb_skid.sv
// Directed bench for latch_mem_wb_skid with two write channels.
module tb_latch_mem_wb_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CH = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [CH-1:0]     mem_en = '0;
    logic [CH*AW-1:0]  mem_addr = '0;
    logic [CH*DW-1:0]  mem_data = '0;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic [CH-1:0]     wb_en;
    logic [CH*AW-1:0]  wb_addr;
    logic [CH*DW-1:0]  wb_data;
    logic [1:0]        occupancy;

    int vectors = 0;
    int miscompares = 0;

    latch_mem_wb_skid #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush                     (flush),
        .mem_valid                 (mem_valid),
        .mem_ready                 (mem_ready),
        .mem_register_write_enable (mem_en),
        .mem_register_write_address(mem_addr),
        .mem_register_write_data   (mem_data),
        .wb_valid                  (wb_valid),
        .wb_ready                  (wb_ready),
        .wb_register_write_enable  (wb_en),
        .wb_register_write_address (wb_addr),
        .wb_register_write_data    (wb_data),
        .occupancy                 (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [CH-1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0);
        mem_valid = 1'b1;
        mem_en    = en;
        mem_addr  = {5'd0, a0};
        mem_data  = {32'd0, d0};
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_en", 64'(wb_en), 64'd0);
        check("rst_wb_addr", 64'(wb_addr), 64'd0);
        check("rst_wb_data", 64'(wb_data), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single accept with channel 0 enabled
        wb_ready = 1'b1;
        offer(2'b01, 5'd3, 32'hDEADBEEF);
        step();
        mem_valid = 1'b0;
        check("t1_wb_valid", 64'(wb_valid), 64'd1);
        check("t1_wb_en", 64'(wb_en), 64'd1);
        check("t1_addr0", 64'(wb_addr[AW-1:0]), 64'd3);
        check("t1_data0", 64'(wb_data[DW-1:0]), 64'hDEADBEEF);
        step();
        check("t1_wb_valid_after", 64'(wb_valid), 64'd0);
        check("t1_occ_after", 64'(occupancy), 64'd0);

        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) begin
            offer(2'b01, 5'd1, 32'(i));
            check("t2_mem_ready", 64'(mem_ready), 64'd1);
            step();
            check("t2_wb_valid", 64'(wb_valid), 64'd1);
            check("t2_data", 64'(wb_data[DW-1:0]), 64'(i));
        end
        mem_valid = 1'b0;
        step();
        check("t2_drained", 64'(wb_valid), 64'd0);

        // Back-pressure: 10 and 11 absorbed, 12 held upstream
        wb_ready = 1'b0;
        offer(2'b01, 5'd2, 32'd10);
        step();
        check("t3_occ1", 64'(occupancy), 64'd1);
        check("t3_ready1", 64'(mem_ready), 64'd1);
        offer(2'b01, 5'd2, 32'd11);
        step();
        check("t3_occ2", 64'(occupancy), 64'd2);
        check("t3_ready_low", 64'(mem_ready), 64'd0);
        offer(2'b01, 5'd2, 32'd12);
        step();
        check("t3_occ_hold", 64'(occupancy), 64'd2);
        check("t3_head_stable", 64'(wb_data[DW-1:0]), 64'd10);
        check("t3_en_stable", 64'(wb_en), 64'd1);
        wb_ready = 1'b1;
        step();
        check("t3_out11", 64'(wb_data[DW-1:0]), 64'd11);
        check("t3_ready_back", 64'(mem_ready), 64'd1);
        check("t3_occ_after_pop", 64'(occupancy), 64'd1);
        step();
        mem_valid = 1'b0;
        check("t3_out12", 64'(wb_data[DW-1:0]), 64'd12);
        check("t3_valid12", 64'(wb_valid), 64'd1);
        step();
        check("t3_empty", 64'(occupancy), 64'd0);

        // Flush from FULL with a simultaneous offer
        wb_ready = 1'b0;
        offer(2'b01, 5'd4, 32'd20);
        step();
        offer(2'b01, 5'd4, 32'd21);
        step();
        check("t4_full", 64'(occupancy), 64'd2);
        offer(2'b01, 5'd4, 32'd99);
        flush = 1'b1;
        step();
        flush = 1'b0;
        mem_valid = 1'b0;
        check("t4_occ", 64'(occupancy), 64'd0);
        check("t4_wb_valid", 64'(wb_valid), 64'd0);
        check("t4_mem_ready", 64'(mem_ready), 64'd1);

        // Flush in ONE with an acceptable offer: the offer must be ignored
        offer(2'b01, 5'd4, 32'd50);
        step();
        check("t4b_occ1", 64'(occupancy), 64'd1);
        offer(2'b01, 5'd4, 32'd99);
        flush = 1'b1;
        step();
        flush = 1'b0;
        mem_valid = 1'b0;
        check("t4b_occ", 64'(occupancy), 64'd0);
        check("t4b_wb_valid", 64'(wb_valid), 64'd0);
        step();
        check("t4b_no99", 64'(wb_valid), 64'd0);

        // Asynchronous reset while FULL
        offer(2'b11, 5'd5, 32'd30);
        step();
        offer(2'b11, 5'd5, 32'd31);
        step();
        mem_valid = 1'b0;
        check("t5_full", 64'(occupancy), 64'd2);
        check("t5_en_before", 64'(wb_en), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t5_wb_valid", 64'(wb_valid), 64'd0);
        check("t5_wb_en", 64'(wb_en), 64'd0);
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_mem_ready", 64'(mem_ready), 64'd1);
        #1;
        reset = 1'b0;

        // All-zero-enable entry is still a valid, poppable entry
        wb_ready = 1'b1;
        offer(2'b00, 5'd7, 32'd77);
        step();
        mem_valid = 1'b0;
        check("t6_wb_valid", 64'(wb_valid), 64'd1);
        check("t6_wb_en", 64'(wb_en), 64'd0);
        check("t6_data", 64'(wb_data[DW-1:0]), 64'd77);
        step();
        check("t6_popped", 64'(wb_valid), 64'd0);
        check("t6_occ", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_latch_mem_wb_skid
